// File: rtl/pc_unit.sv
// Program counter with optional circular return-address stack.
// Define PC_RAS_EN to build the stack; otherwise call/ret are ignored and the status flags are constants.
module pc_unit #(
  parameter int              AW        = 32,
  parameter int              STEP      = 4,
  parameter logic [AW-1:0]   RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          we,
  input  logic [AW-1:0] wd,
  input  logic          ib,
  input  logic [AW-1:0] bv,
  input  logic          call,
  input  logic          ret,
  output logic [AW-1:0] iaddrout,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_err
);

  localparam logic [AW-1:0] STEP_V = AW'(STEP);

  logic [AW-1:0] pc_reg;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] iaddr_reg;
  logic [AW-1:0] seq_addr;
  logic [AW-1:0] br_addr;

  // Carries out of the MSB are dropped, so the PC wraps modulo 2^AW.
  assign seq_addr = pc_reg + STEP_V;
  assign br_addr  = pc_reg + bv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg    <= RESET_VEC;
      iaddr_reg <= RESET_VEC;
    end else if (!stall) begin
      iaddr_reg <= pc_reg;
      pc_reg    <= pc_next;
    end
  end

  assign iaddrout = iaddr_reg;

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] wptr_reg;
  logic [PW-1:0] wptr_next;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] wptr_inc;
  logic [CW-1:0] depth_reg;
  logic [CW-1:0] depth_next;
  logic          empty_reg;
  logic          full_reg;
  logic          err_reg;
  logic          err_next;
  logic          do_push;
  logic          do_pop;

  // wptr points at the slot the next push writes; the newest entry sits just below it.
  assign top_idx  = (wptr_reg == '0) ? PW'(RAS_DEPTH - 1) : wptr_reg - 1'b1;
  assign wptr_inc = (wptr_reg == PW'(RAS_DEPTH - 1)) ? '0 : wptr_reg + 1'b1;

  always_comb begin
    pc_next    = pc_reg;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    err_next   = err_reg;
    wptr_next  = wptr_reg;
    depth_next = depth_reg;
    if (!stall) begin
      if (we) begin
        pc_next = wd;
      end else if (ret && (depth_reg != '0)) begin
        pc_next = ras_mem[top_idx];
        do_pop  = 1'b1;
      end else begin
        if (ret) err_next = 1'b1;
        if (ib) begin
          pc_next = br_addr;
          do_push = call;
        end else begin
          pc_next = seq_addr;
        end
      end
    end
    if (do_push) begin
      wptr_next = wptr_inc;
      // A full stack overwrites its oldest entry, which is exactly the slot at wptr.
      if (depth_reg == CW'(RAS_DEPTH)) err_next = 1'b1;
      else depth_next = depth_reg + 1'b1;
    end else if (do_pop) begin
      wptr_next  = top_idx;
      depth_next = depth_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_reg  <= '0;
      depth_reg <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      wptr_reg  <= wptr_next;
      depth_reg <= depth_next;
      empty_reg <= (depth_next == '0);
      full_reg  <= (depth_next == CW'(RAS_DEPTH));
      err_reg   <= err_next;
    end
  end

  // Storage is not reset; a zero depth makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) ras_mem[wptr_reg] <= seq_addr;
  end

  assign ras_empty = empty_reg;
  assign ras_full  = full_reg;
  assign ras_err   = err_reg;
`else
  logic unused_ras;
  assign unused_ras = call ^ ret;

  always_comb begin
    pc_next = pc_reg;
    if (!stall) begin
      if (we)      pc_next = wd;
      else if (ib) pc_next = br_addr;
      else         pc_next = seq_addr;
    end
  end

  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a reference model queues the expected fetch address per edge.
// Stack expectations follow PC_RAS_EN, matching whichever build is compiled.
module tb_pc_unit;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic        ib = 1'b0;
  logic [31:0] bv = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] iaddrout;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ia;
  logic        m_err;
  logic [31:0] m_stk[$];
  logic [31:0] sb_q[$];

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .we(we), .wd(wd), .ib(ib), .bv(bv),
    .call(call), .ret(ret), .iaddrout(iaddrout), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    logic e_empty, e_full, e_err;
    e_empty = RAS ? (m_stk.size() == 0) : 1'b1;
    e_full  = RAS ? (m_stk.size() == DEPTH) : 1'b0;
    e_err   = RAS ? m_err : 1'b0;
    check({tag, "_empty"}, {31'd0, ras_empty}, {31'd0, e_empty});
    check({tag, "_full"},  {31'd0, ras_full},  {31'd0, e_full});
    check({tag, "_err"},   {31'd0, ras_err},   {31'd0, e_err});
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_ia = '0;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  // Assert reset between edges, check it acts at once and across an edge, then release.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    model_reset();
    #1;
    check({tag, "_async_ia"}, iaddrout, 32'h0);
    check_flags({tag, "_async"});
    @(posedge clk);
    #1;
    check({tag, "_held_ia"}, iaddrout, 32'h0);
    check_flags({tag, "_held"});
    {stall, we, ib, call, ret} = '0;
    wd = '0;
    bv = '0;
    reset = 1'b1;
  endtask

  task automatic cyc(input string tag, input logic s, input logic w, input logic [31:0] wdv,
                     input logic i, input logic [31:0] bvv, input logic c, input logic r);
    logic [31:0] npc;
    logic [31:0] tmp;
    stall = s; we = w; wd = wdv; ib = i; bv = bvv; call = c; ret = r;
    if (!s) begin
      m_ia = m_pc;
      if (w) begin
        npc = wdv;
      end else if (RAS && r && (m_stk.size() > 0)) begin
        npc = m_stk.pop_back();
      end else begin
        if (RAS && r) m_err = 1'b1;
        if (i) begin
          npc = m_pc + bvv;
          if (RAS && c) begin
            m_stk.push_back(m_pc + 32'd4);
            if (m_stk.size() > DEPTH) begin
              tmp = m_stk.pop_front();
              m_err = 1'b1;
            end
          end
        end else begin
          npc = m_pc + 32'd4;
        end
      end
      m_pc = npc;
    end
    sb_q.push_back(m_ia);
    @(posedge clk);
    #1;
    check({tag, "_ia"}, iaddrout, sb_q.pop_front());
    check_flags(tag);
    $display("step %-10s stall=%0b we=%0b ib=%0b call=%0b ret=%0b iaddrout=%h empty=%0b full=%0b err=%0b",
             tag, s, w, i, c, r, iaddrout, ras_empty, ras_full, ras_err);
  endtask

  initial begin
    model_reset();
    #1;
    check("por_ia", iaddrout, 32'h0);
    check_flags("por");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Idle after reset: 0, 4, 8
    repeat (3) cyc("idle", 0, 0, 0, 0, 0, 0, 0);

    // Backward branch, then load winning over a branch
    cyc("ld10",   0, 1, 32'h10, 0, 0, 0, 0);
    cyc("brback", 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 0);
    cyc("ldbr",   0, 1, 32'h100, 1, 32'h40, 0, 0);
    cyc("idle",   0, 0, 0, 0, 0, 0, 0);
    cyc("idle",   0, 0, 0, 0, 0, 0, 0);

    // Single call / return
    cyc("ld20",  0, 1, 32'h20, 0, 0, 0, 0);
    cyc("call",  0, 0, 0, 1, 32'h40, 1, 0);
    cyc("idle",  0, 0, 0, 0, 0, 0, 0);
    cyc("idle",  0, 0, 0, 0, 0, 0, 0);
    cyc("ret",   0, 0, 0, 0, 0, 0, 1);
    cyc("idle",  0, 0, 0, 0, 0, 0, 0);

    // Overflow: five calls, five returns
    do_reset("rst1");
    cyc("ld1000", 0, 1, 32'h1000, 0, 0, 0, 0);
    repeat (5) cyc("ovcall", 0, 0, 0, 1, 32'h100, 1, 0);
    repeat (5) cyc("ovret", 0, 0, 0, 0, 0, 0, 1);
    cyc("idle", 0, 0, 0, 0, 0, 0, 0);

    // Underflow, ret+call, load with call/ret, reset mid-call
    do_reset("rst2");
    cyc("uflow",   0, 0, 0, 0, 0, 0, 1);
    cyc("ld200",   0, 1, 32'h200, 0, 0, 0, 0);
    cyc("call1",   0, 0, 0, 1, 32'h10, 1, 0);
    cyc("retcall", 0, 0, 0, 1, 32'h10, 1, 1);
    cyc("call2",   0, 0, 0, 1, 32'h10, 1, 0);
    cyc("ldcr",    0, 1, 32'h300, 1, 32'h10, 1, 1);
    cyc("ret2",    0, 0, 0, 0, 0, 0, 1);
    cyc("call3",   0, 0, 0, 1, 32'h20, 1, 0);
    ib = 1'b1; call = 1'b1; bv = 32'h20;
    do_reset("rst3");
    cyc("retempty", 0, 0, 0, 0, 0, 0, 1);
    cyc("idle",     0, 0, 0, 0, 0, 0, 0);

    // Stall holds a pending branch for three cycles
    cyc("ld40", 0, 1, 32'h40, 0, 0, 0, 0);
    repeat (3) cyc("stall", 1, 0, 0, 1, 32'h10, 1, 0);
    cyc("unstall", 0, 0, 0, 1, 32'h10, 0, 0);
    cyc("idle",    0, 0, 0, 0, 0, 0, 0);

    // Wrap at the top of the address space, then async reset from a nonzero PC
    cyc("ldtop", 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    cyc("wrap",  0, 0, 0, 0, 0, 0, 0);
    cyc("idle",  0, 0, 0, 0, 0, 0, 0);
    cyc("ldf0",  0, 1, 32'hFFFF_FFF0, 0, 0, 0, 0);
    cyc("idle",  0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset("rst4");
    repeat (2) cyc("idle", 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter AW, default 32: address width in bits.
REQ-002 The block SHALL have parameter STEP, default 4: sequential increment.
REQ-003 The block SHALL have parameter RESET_VEC, default 0: PC value loaded on reset.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 4: number of return-address-stack entries, 2..16.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port stall, input, 1 bit: holds all state for the cycle.
REQ-008 The block SHALL have ports we (input, 1 bit) and wd (input, AW bits): absolute PC load.
REQ-009 The block SHALL have ports ib (input, 1 bit) and bv (input, AW bits): PC-relative branch, bv two's complement.
REQ-010 The block SHALL have port call, input, 1 bit: with ib, push the link address.
REQ-011 The block SHALL have port ret, input, 1 bit: pop the return target.
REQ-012 The block SHALL have port iaddrout, output, AW bits: registered fetch address.
REQ-013 The block SHALL have ports ras_empty and ras_full, output, 1 bit each: stack status.
REQ-014 The block SHALL have port ras_err, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-015 Internal register pc SHALL be updated once per clk edge; iaddrout SHALL take the pre-update pc value on the same edge, giving one cycle of latency.
REQ-016 Next-pc priority SHALL be: stall (hold) > we (wd) > ret with stack non-empty (top entry) > ib (pc+bv) > sequential (pc+STEP).
REQ-017 All additions SHALL be modulo 2^AW; the carry SHALL be discarded, so pc at 2^AW-STEP wraps to 0.
REQ-018 With stall=1, pc, iaddrout, the stack and ras_err SHALL all hold their values.
REQ-019 call SHALL take effect only when ib=1 and it is the selected action; it then pushes pc+STEP.
REQ-020 Push onto a full stack SHALL overwrite the oldest entry (circular), keep depth at RAS_DEPTH and set ras_err.
REQ-021 ret on an empty stack SHALL behave as ib/sequential per priority, leave the stack empty and set ras_err.
REQ-022 ret and call together with a non-empty stack SHALL pop only; call SHALL be ignored.
REQ-023 we=1 SHALL leave the stack unchanged even when call or ret is asserted.
REQ-024 ras_empty and ras_full SHALL be registered state reflecting the stack depth after the edge.
REQ-025 ras_err SHALL clear only on reset.

Reset
REQ-026 Assertion of reset SHALL immediately, without waiting for a clk edge, force pc=RESET_VEC, iaddrout=RESET_VEC, stack depth 0, ras_empty=1, ras_full=0 and ras_err=0.
REQ-027 The first edge after reset deasserts SHALL perform a normal update, so iaddrout=RESET_VEC and pc=RESET_VEC+STEP if idle.
REQ-028 Reset asserted mid-call or mid-return SHALL discard all stack contents.

Configuration
REQ-029 With macro PC_RAS_EN defined, the return address stack and REQ-019..REQ-023 SHALL be implemented.
REQ-030 Without PC_RAS_EN, no stack storage SHALL exist: ret and call are ignored, call+ib acts as a plain branch, ras_empty is tied 1, ras_full is tied 0 and ras_err is tied 0.

Verification
REQ-031 Reset released with all inputs 0 and defaults SHALL produce iaddrout 0, 0, 4, 8 on successive edges.
REQ-032 At pc=0x10, ib=1 with bv=0xFFFFFFF8 SHALL give pc=0x08; we=1 with wd=0x100 asserted together with ib SHALL give pc=0x100.
REQ-033 call+ib at pc=0x20 with bv=0x40 SHALL give pc=0x60 and push 0x24; a later ret SHALL give pc=0x24 and ras_empty=1.
REQ-034 Five calls with RAS_DEPTH=4 SHALL set ras_full=1 and ras_err=1; four rets SHALL return the latest four link addresses in LIFO order, and a fifth ret SHALL leave pc sequential.
REQ-035 stall held 3 cycles at pc=0x40 with ib=1 SHALL keep iaddrout and pc constant; releasing stall SHALL then apply the branch.
REQ-036 At pc=0xFFFFFFFC with idle inputs, the next pc SHALL be 0; reset asserted between edges SHALL immediately force iaddrout to 0.
